// File: rtl/mem_drv_pkg.sv
// -----------------------------------------------------------------------------
// mem_drv_pkg
// Shared types for the memory command driver: the command opcode, the driver
// FSM state encoding and the queued command record, plus a small helper that
// maps an opcode to the FSM state that performs it.
// -----------------------------------------------------------------------------
package mem_drv_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   // Increment used by the 16-bit completion counters (wraps naturally).
   localparam logic [15:0] CNT16_ONE = 16'd1;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RSP   = 2'd3
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   // State entered when a command with this opcode is issued.
   function automatic state_e issue_state(input op_e op);
      state_e st;
      case (op)
         OP_WR:   st = WRITE;
         OP_RD:   st = READ;
         default: st = IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// -----------------------------------------------------------------------------
// mem_cmd_fifo
// Synchronous command FIFO, DEPTH entries (power of two). The head entry is
// presented combinationally from storage so the consumer can decode it in the
// same cycle it pops. A push while full is dropped, even if a pop happens in
// the same cycle; flags come from a registered occupancy count.
//
// Ports
//   clk          clock
//   rst_n_i      synchronous active-low reset (empties the FIFO)
//   push_i       write push_data_i at the tail (ignored when full)
//   push_data_i  command to enqueue
//   pop_i        discard the head entry (ignored when empty)
//   head_o       current head entry
//   full_o       FIFO holds DEPTH entries
//   empty_o      FIFO holds no entries
// -----------------------------------------------------------------------------
module mem_cmd_fifo
   import mem_drv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n_i,
   input  logic push_i,
   input  cmd_t push_data_i,
   input  logic pop_i,
   output cmd_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   cmd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (count_q == CNT_FULL);
   assign empty_o   = (count_q == CNT_ZERO);
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign head_o    = mem_q[rd_ptr_q];

   // Next pointer and occupancy values; pointers wrap because DEPTH is 2^n.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are qualified by the count, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/mem_cmd_driver.sv
// -----------------------------------------------------------------------------
// mem_cmd_driver
// Accepts read/write commands into a FIFO and plays them, in order, onto a
// simple strobed memory port. Writes take one cycle each and can run
// back-to-back; reads take one strobe cycle and then park in RSP until the
// downstream consumer takes the response.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready     upstream command handshake
//   cmd_op, cmd_addr,       command: 0 = read, 1 = write; address; write data
//   cmd_wdata
//   addr, wr_data_reg       memory address and write data (held when idle)
//   rd, wr                  one-cycle memory strobes, never both high
//   data                    memory read data, sampled at the end of READ
//   rsp_valid/rsp_ready     read response handshake
//   rsp_data, rsp_addr      read data and the address it came from
//   wr_count, rd_count      completed writes / reads, wrapping 16-bit
// -----------------------------------------------------------------------------
module mem_cmd_driver
   import mem_drv_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [15:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic [15:0] addr,
   output logic [15:0] wr_data_reg,
   output logic        rd,
   output logic        wr,
   input  logic [15:0] data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [15:0] rsp_addr,
   output logic [15:0] wr_count,
   output logic [15:0] rd_count
);

   state_e      state_q, state_d;
   logic        rdy_q;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic [15:0] rsp_addr_q, rsp_addr_d;
   logic [15:0] wr_count_q, wr_count_d;
   logic [15:0] rd_count_q, rd_count_d;

   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        push_s;
   logic        pop_s;
   logic        slot_free_s;
   logic        rd_s;
   logic        wr_s;
   cmd_t        push_cmd_s;
   cmd_t        head_s;

   // rdy_q holds cmd_ready low for the reset cycle and the edge that
   // releases it; from then on readiness depends only on the full flag.
   assign cmd_ready = rdy_q && !fifo_full_s;
   assign push_s    = cmd_valid && cmd_ready;
   assign pop_s     = slot_free_s && !fifo_empty_s;

   // Pack the upstream command fields into the queued record.
   always_comb begin
      push_cmd_s       = '0;
      push_cmd_s.op    = op_e'(cmd_op);
      push_cmd_s.addr  = cmd_addr;
      push_cmd_s.wdata = cmd_wdata;
   end

   mem_cmd_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n_i     (reset_n),
      .push_i      (push_s),
      .push_data_i (push_cmd_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Whether the memory port is free to take the next command at the end of
   // this cycle: a finished write, idle, or a response being handed off.
   always_comb begin
      slot_free_s = 1'b0;
      case (state_q)
         IDLE:    slot_free_s = 1'b1;
         WRITE:   slot_free_s = 1'b1;
         READ:    slot_free_s = 1'b0;
         RSP:     slot_free_s = rsp_ready;
         default: slot_free_s = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, WRITE: begin
            if (pop_s) begin
               state_d = issue_state(head_s.op);
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            state_d = RSP;
         end
         RSP: begin
            if (pop_s) begin
               state_d = issue_state(head_s.op);
            end else if (rsp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RSP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: memory strobes decoded from the state register.
   always_comb begin
      rd_s = 1'b0;
      wr_s = 1'b0;
      case (state_q)
         WRITE:   wr_s = 1'b1;
         READ:    rd_s = 1'b1;
         default: begin
            rd_s = 1'b0;
            wr_s = 1'b0;
         end
      endcase
   end

   // Datapath next values: address/data load on issue, response capture at
   // the end of READ, completion counting at the end of WRITE/READ.
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_addr_d  = rsp_addr_q;
      wr_count_d  = wr_count_q;
      rd_count_d  = rd_count_q;

      if (pop_s) begin
         addr_d = head_s.addr;
         if (head_s.op == OP_WR) begin
            wdata_d = head_s.wdata;
         end else begin
            wdata_d = wdata_q;
         end
      end else begin
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end

      case (state_q)
         WRITE: begin
            wr_count_d = wr_count_q + CNT16_ONE;
         end
         READ: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data;
            rsp_addr_d  = addr_q;
            rd_count_d  = rd_count_q + CNT16_ONE;
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
            end else begin
               rsp_valid_d = rsp_valid_q;
            end
         end
         default: begin
            rsp_valid_d = rsp_valid_q;
         end
      endcase
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q      <= 16'h0000;
         wdata_q     <= 16'h0000;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'h0000;
         rsp_addr_q  <= 16'h0000;
         wr_count_q  <= 16'h0000;
         rd_count_q  <= 16'h0000;
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_addr_q  <= rsp_addr_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
      end
   end

   assign addr        = addr_q;
   assign wr_data_reg = wdata_q;
   assign rd          = rd_s;
   assign wr          = wr_s;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_addr    = rsp_addr_q;
   assign wr_count    = wr_count_q;
   assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_mem_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_mem_cmd_driver
// Scoreboard bench: every accepted command pushes its expected memory access
// (and, for reads, its expected response from a bench-side memory model);
// strobes and response handshakes pop and compare. Inputs change 1 time unit
// after posedge, the monitor samples on negedge.
// -----------------------------------------------------------------------------
module tb_mem_cmd_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic [15:0] addr;
   logic [15:0] wr_data_reg;
   logic        rd;
   logic        wr;
   logic [15:0] data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [15:0] rsp_addr;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0] exp_mem_q [$];   // {op, addr, wdata}
   logic [31:0] exp_rsp_q [$];   // {addr, data}
   logic [15:0] mem_dev   [256]; // memory device driven onto data
   logic [15:0] model_mem [256]; // expected memory contents, in command order
   int          wr_run;
   int          wr_run_max;
   logic [15:0] last_rsp_data;
   logic [15:0] last_rsp_addr;

   always #5 clk = ~clk;

   mem_cmd_driver #(.CMD_DEPTH(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .addr        (addr),
      .wr_data_reg (wr_data_reg),
      .rd          (rd),
      .wr          (wr),
      .data        (data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_addr    (rsp_addr),
      .wr_count    (wr_count),
      .rd_count    (rd_count)
   );

   function automatic logic [15:0] init_word(input int i);
      return 16'hC300 ^ 16'(i * 37);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory device: reset to a known pattern, written on wr strobes.
   assign data = mem_dev[addr[7:0]];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) mem_dev[i] <= init_word(i);
      end else if (wr) begin
         mem_dev[addr[7:0]] <= wr_data_reg;
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic [32:0] e;
      logic [31:0] r;
      wr_run = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
            wr_run = 0;
         end else begin
            if (cmd_valid && cmd_ready) begin
               exp_mem_q.push_back({cmd_op, cmd_addr, cmd_wdata});
               if (cmd_op) model_mem[cmd_addr[7:0]] = cmd_wdata;
               else        exp_rsp_q.push_back({cmd_addr, model_mem[cmd_addr[7:0]]});
            end
            check_eq("rd_wr_exclusive", {31'd0, rd && wr}, 32'd0);
            if (rd || wr) begin
               if (exp_mem_q.size() == 0) begin
                  check_eq("unexpected_strobe", {30'd0, rd, wr}, 32'd0);
               end else begin
                  e = exp_mem_q.pop_front();
                  check_eq("strobe_op", {31'd0, wr}, {31'd0, e[32]});
                  check_eq("strobe_addr", {16'd0, addr}, {16'd0, e[31:16]});
                  if (wr) check_eq("strobe_wdata", {16'd0, wr_data_reg}, {16'd0, e[15:0]});
               end
            end
            if (wr) begin
               wr_run++;
               if (wr_run > wr_run_max) wr_run_max = wr_run;
            end else begin
               wr_run = 0;
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_rsp_q.size() == 0) begin
                  check_eq("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
               end else begin
                  r = exp_rsp_q.pop_front();
                  check_eq("rsp_addr", {16'd0, rsp_addr}, {16'd0, r[31:16]});
                  check_eq("rsp_data", {16'd0, rsp_data}, {16'd0, r[15:0]});
                  last_rsp_addr = rsp_addr;
                  last_rsp_data = rsp_data;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic op, input logic [15:0] a, input logic [15:0] d);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check_eq("send_timeout", n, 32'd0);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_mem_q.size() != 0 || exp_rsp_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      check_eq({tag, "_drain_timeout"}, {31'd0, n >= 2000}, 32'd0);
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [32:0] flood [6];
      int          acc;
      logic        will;

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_addr  = 16'h0000;
      cmd_wdata = 16'h0000;
      rsp_ready = 1'b1;
      wr_run_max = 0;
      last_rsp_data = 16'h0000;
      last_rsp_addr = 16'h0000;

      // Reset state.
      tick();
      tick();
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("rst_rd", {31'd0, rd}, 32'd0);
      check_eq("rst_wr", {31'd0, wr}, 32'd0);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_addr", {16'd0, addr}, 32'd0);
      check_eq("rst_wdata", {16'd0, wr_data_reg}, 32'd0);
      check_eq("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      check_eq("rst_rsp_addr", {16'd0, rsp_addr}, 32'd0);
      check_eq("rst_wr_count", {16'd0, wr_count}, 32'd0);
      check_eq("rst_rd_count", {16'd0, rd_count}, 32'd0);
      reset_n = 1'b1;
      tick();
      check_eq("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Write then read the same address.
      wr_run_max = 0;
      send(1'b1, 16'h0010, 16'hBEEF);
      send(1'b0, 16'h0010, 16'h0000);
      wait_drain("wr_rd");
      check_eq("wr_rd_pulse_len", wr_run_max, 32'd1);
      check_eq("wr_rd_rsp_data", {16'd0, last_rsp_data}, 32'h0000BEEF);
      check_eq("wr_rd_rsp_addr", {16'd0, last_rsp_addr}, 32'h00000010);
      check_eq("wr_rd_wr_count", {16'd0, wr_count}, 32'd1);
      check_eq("wr_rd_rd_count", {16'd0, rd_count}, 32'd1);
      check_eq("idle_addr_hold", {16'd0, addr}, 32'h00000010);
      check_eq("idle_wdata_hold", {16'd0, wr_data_reg}, 32'h0000BEEF);

      // Four back-to-back writes.
      wr_run_max = 0;
      for (int i = 0; i < 4; i++) send(1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i * 16'h0111));
      wait_drain("b2b");
      check_eq("b2b_wr_run", wr_run_max, 32'd4);
      check_eq("b2b_wr_count", {16'd0, wr_count}, 32'd5);

      // Stalled response, then flood while stalled.
      rsp_ready = 1'b0;
      flood[0] = {1'b1, 16'h0030, 16'h1111};
      flood[1] = {1'b0, 16'h0030, 16'h0000};
      flood[2] = {1'b1, 16'h0031, 16'h2222};
      flood[3] = {1'b0, 16'h0031, 16'h0000};
      flood[4] = {1'b1, 16'h0032, 16'h3333};
      flood[5] = {1'b0, 16'h0032, 16'h0000};
      send(1'b0, 16'h0020, 16'h0000);
      tick();
      tick();
      check_eq("stall_first_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("stall_first_data", {16'd0, rsp_data}, {16'd0, init_word(32)});
      check_eq("stall_wdata_kept", {16'd0, wr_data_reg}, 32'h0000A333);
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         if (acc < 6) begin
            cmd_valid = 1'b1;
            {cmd_op, cmd_addr, cmd_wdata} = flood[acc];
         end else begin
            cmd_valid = 1'b0;
         end
         will = cmd_valid && cmd_ready;
         tick();
         if (will) acc++;
         check_eq("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("stall_rsp_data", {16'd0, rsp_data}, {16'd0, init_word(32)});
         check_eq("stall_rsp_addr", {16'd0, rsp_addr}, 32'h00000020);
         check_eq("stall_strobes", {30'd0, rd, wr}, 32'd0);
      end
      cmd_valid = 1'b0;
      check_eq("flood_accepted", acc, 32'd4);
      check_eq("flood_full_ready", {31'd0, cmd_ready}, 32'd0);
      rsp_ready = 1'b1;
      wait_drain("flood");
      check_eq("flood_wr_count", {16'd0, wr_count}, 32'd7);
      check_eq("flood_rd_count", {16'd0, rd_count}, 32'd4);
      check_eq("flood_last_rsp", {16'd0, last_rsp_data}, 32'h00002222);

      // Reset during READ with a write still queued.
      send(1'b0, 16'h0040, 16'h0000);
      send(1'b1, 16'h0041, 16'hAAAA);
      check_eq("mid_rd_active", {31'd0, rd}, 32'd1);
      reset_n = 1'b0;
      exp_mem_q.delete();
      exp_rsp_q.delete();
      tick();
      check_eq("mid_rst_rd", {31'd0, rd}, 32'd0);
      check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("mid_rst_wr_count", {16'd0, wr_count}, 32'd0);
      check_eq("mid_rst_rd_count", {16'd0, rd_count}, 32'd0);
      check_eq("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      reset_n = 1'b1;
      tick();
      check_eq("mid_rst_ready_back", {31'd0, cmd_ready}, 32'd1);
      for (int k = 0; k < 4; k++) tick();
      check_eq("mid_rst_dropped_wr", {16'd0, wr_count}, 32'd0);
      check_eq("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

      // Counter wrap.
      for (int i = 0; i < 65535; i++) send(1'b1, 16'(i), 16'(i) ^ 16'h3C3C);
      wait_drain("wrap_pre");
      check_eq("wrap_ffff", {16'd0, wr_count}, 32'h0000FFFF);
      send(1'b1, 16'h0055, 16'h7777);
      wait_drain("wrap");
      check_eq("wrap_zero", {16'd0, wr_count}, 32'd0);
      check_eq("wrap_rd_count", {16'd0, rd_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_cmd_driver.md
MEM_CMD_DRIVER -- requirements
Module: mem_cmd_driver

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-006 SHALL have port cmd_op  input  1  0 = read, 1 = write.
REQ-007 SHALL have port cmd_addr  input  16  target address.
REQ-008 SHALL have port cmd_wdata  input  16  write data (ignored for reads).
REQ-009 SHALL have port addr  output  16  memory address.
REQ-010 SHALL have port wr_data_reg  output  16  memory write data.
REQ-011 SHALL have port rd  output  1  memory read strobe.
REQ-012 SHALL have port wr  output  1  memory write strobe.
REQ-013 SHALL have port data  input  16  memory data bus, sampled during reads.
REQ-014 SHALL have port rsp_valid  output  1  read response present.
REQ-015 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-016 SHALL have port rsp_data  output  16  read data.
REQ-017 SHALL have port rsp_addr  output  16  address of the read.
REQ-018 SHALL have ports wr_count, rd_count  output  16  completed writes/reads.

Function
REQ-019 SHALL push when cmd_valid && cmd_ready; cmd_ready = !fifo_full, registered-state derived, no combinational path from cmd_valid.
REQ-020 SHALL refuse a push when full even if a pop occurs in the same cycle.
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, RSP.
REQ-022 IDLE: FIFO non-empty -> pop head, load addr (plus wr_data_reg on write), go WRITE or READ next cycle; empty -> stay.
REQ-023 WRITE: wr = 1, rd = 0 for exactly one cycle; wr_count += 1 at exit; if FIFO non-empty, pop and go directly to WRITE/READ, else IDLE.
REQ-024 READ: rd = 1, wr = 0 for exactly one cycle; at its closing posedge capture data into rsp_data, addr into rsp_addr, set rsp_valid, rd_count += 1, go RSP.
REQ-025 RSP: rd = wr = 0; hold rsp_valid/rsp_data/rsp_addr stable until rsp_ready; on rsp_valid && rsp_ready, clear rsp_valid and behave as the REQ-023 exit (pop-and-issue or IDLE).
REQ-026 SHALL never assert rd and wr together; both 0 in IDLE and RSP.
REQ-027 addr and wr_data_reg SHALL hold their last values when idle; wr_data_reg is unchanged by reads.
REQ-028 Peak throughput SHALL be one write per cycle for back-to-back writes; one read per two cycles with rsp_ready tied high.
REQ-029 wr_count/rd_count SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-030 Commands SHALL execute strictly in acceptance order.

Reset
REQ-031 With reset_n = 0 at posedge clk: FSM to IDLE; FIFO emptied; cmd_ready = 0 during reset, 1 the cycle after; rd, wr, rsp_valid = 0; addr, wr_data_reg, rsp_data, rsp_addr, wr_count, rd_count = 0.
REQ-032 Reset mid-operation SHALL abort the in-flight access and drop queued commands and any pending response.

Structure
REQ-033 Package mem_drv_pkg SHALL hold op enum (OP_RD, OP_WR), FSM state enum, and cmd struct {op, addr, wdata}.
REQ-034 Command FIFO SHALL be sub-module mem_cmd_fifo (parameterised depth, synchronous active-low reset, full/empty flags).

Verification
REQ-035 Write 16'h0010 <- 16'hBEEF then read 16'h0010 -> one-cycle wr pulse, then rd pulse; rsp_data = 16'hBEEF, rsp_addr = 16'h0010; wr_count = rd_count = 1.
REQ-036 Four back-to-back writes -> wr high four consecutive cycles, addr/wr_data_reg change every cycle, wr_count = 4.
REQ-037 rsp_ready held 0 for 5 cycles after a read -> rsp_valid/rsp_data stable, rd = wr = 0, cmd_ready deasserts once 4 queued.
REQ-038 Flood 6 commands while stalled -> exactly 4 accepted, cmd_ready = 0 when full; order preserved on drain.
REQ-039 Assert reset_n = 0 during READ -> next cycle rd = 0, rsp_valid = 0, counters 0, FIFO empty.
REQ-040 Preset wr_count to 16'hFFFF via 65535 writes, then one write -> wr_count = 16'h0000.
